// File: rtl/regfile_sb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | regfile_sb : register file with write-through reads, link-write priority, |
// |              hardwired r0, v0/a0 taps and a per-register busy scoreboard. |
// | Revision   : 1.0                                                          |
// +----------------------------------------------------------------------------+
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int LINK_REG = 31,
    parameter int V0_REG   = 2,
    parameter int A0_REG   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              link_en,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              busy1,
    output logic              busy2,
    output logic [DATA_W-1:0] v0,
    output logic [DATA_W-1:0] a0
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] c_link = ADDR_W'(LINK_REG);
    localparam logic [ADDR_W-1:0] c_v0   = ADDR_W'(V0_REG);
    localparam logic [ADDR_W-1:0] c_a0   = ADDR_W'(A0_REG);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic [DEPTH-1:0]  w_busy_nxt;
    logic [ADDR_W-1:0] w_wr_addr;
    logic              w_wr_eff;

    // Link writes steal the write port; writes to r0 are dropped here so
    // neither storage nor bypass ever sees them.
    assign w_wr_addr = link_en ? c_link : wr_addr;
    assign w_wr_eff  = (link_en || wr_en) && (w_wr_addr != '0);

    // Clear-then-set so a re-issue in the writeback cycle keeps the reg busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr_eff)
            w_busy_nxt[w_wr_addr] = 1'b0;
        if (iss_en && (iss_addr != '0))
            w_busy_nxt[iss_addr] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
            r_busy   <= '0;
            rd_data1 <= '0;
            rd_data2 <= '0;
            busy1    <= 1'b0;
            busy2    <= 1'b0;
            v0       <= '0;
            a0       <= '0;
        end else begin
            if (w_wr_eff)
                r_mem[w_wr_addr] <= wr_data;
            r_busy   <= w_busy_nxt;
            rd_data1 <= (w_wr_eff && (rd_addr1 == w_wr_addr)) ? wr_data : r_mem[rd_addr1];
            rd_data2 <= (w_wr_eff && (rd_addr2 == w_wr_addr)) ? wr_data : r_mem[rd_addr2];
            busy1    <= w_busy_nxt[rd_addr1];
            busy2    <= w_busy_nxt[rd_addr2];
            v0       <= (w_wr_eff && (c_v0 == w_wr_addr)) ? wr_data : r_mem[c_v0];
            a0       <= (w_wr_eff && (c_a0 == w_wr_addr)) ? wr_data : r_mem[c_a0];
        end
    end

endmodule
`default_nettype wire
